trng_sampler: RTL

TRNG_SAMPLER -- requirements
Module: trng_sampler

---
 rtl/trng_sampler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/trng_sampler.sv
// Ring-oscillator TRNG front end: XOR + 2-flop sync, discard, repetition-count health test, W-bit packer.
// Optional von Neumann debiasing on post-discard samples when VN_CORRECTOR_EN is defined.
`timescale 1ns/1ps
module trng_sampler #(
  parameter int NRO       = 40,
  parameter int W         = 32,
  parameter int DISCARD   = 64,
  parameter int RCT_LIMIT = 32
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NRO-1:0] RO_IN,
  input  logic           EN,
  output logic [W-1:0]   DATA_O,
  output logic           VALID_O,
  input  logic           READY_I,
  output logic           FAIL_O
);

  localparam int CW = $clog2(W + 1);
  localparam int DW = $clog2(DISCARD + 2);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] disc_cnt_q, disc_cnt_d;
  logic [7:0]    rct_cnt_q, rct_cnt_d;
  logic          prev_q, prev_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          fail_q, fail_d;

  logic          raw_bit;
  logic          post_smp;
  logic          bit_vld;
  logic          bit_dat;
  logic          out_free;
  logic          acc_full;

  assign raw_bit = sync2_q;

  always_comb begin
    sync1_d    = ^RO_IN;
    sync2_d    = sync1_q;
    disc_cnt_d = disc_cnt_q;
    post_smp   = 1'b0;
    if (EN) begin
      if (disc_cnt_q < DW'(DISCARD)) begin
        disc_cnt_d = disc_cnt_q + DW'(1);
      end else begin
        post_smp = 1'b1;
      end
    end
  end

  // Health test sees every post-discard sample, before any debiasing.
  always_comb begin
    rct_cnt_d = rct_cnt_q;
    prev_d    = prev_q;
    if (post_smp) begin
      prev_d = raw_bit;
      if (rct_cnt_q == 8'd0 || raw_bit != prev_q) begin
        rct_cnt_d = 8'd1;
      end else if (rct_cnt_q < 8'(RCT_LIMIT)) begin
        rct_cnt_d = rct_cnt_q + 8'd1;
      end
    end
    fail_d = fail_q | (rct_cnt_d == 8'(RCT_LIMIT));
  end

`ifdef VN_CORRECTOR_EN
  logic pair_q, pair_d;
  logic first_q, first_d;

  // Second sample of a pair emits the first sample when the two differ.
  always_comb begin
    pair_d  = pair_q;
    first_d = first_q;
    bit_vld = 1'b0;
    bit_dat = first_q;
    if (post_smp && !fail_q) begin
      if (!pair_q) begin
        pair_d  = 1'b1;
        first_d = raw_bit;
      end else begin
        pair_d  = 1'b0;
        bit_vld = (first_q != raw_bit);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pair_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      pair_q  <= pair_d;
      first_q <= first_d;
    end
  end
`else
  assign bit_vld = post_smp & ~fail_q;
  assign bit_dat = raw_bit;
`endif

  always_comb begin
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    out_free  = ~valid_q | READY_I;
    acc_full  = (bit_cnt_q == CW'(W));
    if (valid_q && READY_I) begin
      valid_d = 1'b0;
    end
    if (!fail_q) begin
      if (acc_full) begin
        // A full accumulator waits for the output register; meanwhile new bits are lost.
        if (out_free) begin
          data_d    = acc_q;
          valid_d   = 1'b1;
          bit_cnt_d = '0;
          if (bit_vld) begin
            acc_d     = (acc_q << 1) | W'(bit_dat);
            bit_cnt_d = CW'(1);
          end
        end
      end else if (bit_vld) begin
        acc_d = (acc_q << 1) | W'(bit_dat);
        if (bit_cnt_q == CW'(W - 1) && out_free) begin
          data_d    = acc_d;
          valid_d   = 1'b1;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
    end
    if (fail_d) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      disc_cnt_q <= '0;
      rct_cnt_q  <= '0;
      prev_q     <= 1'b0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      disc_cnt_q <= disc_cnt_d;
      rct_cnt_q  <= rct_cnt_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fail_q     <= fail_d;
    end
  end

  assign DATA_O  = data_q;
  assign VALID_O = valid_q;
  assign FAIL_O  = fail_q;

endmodule
